// File: rtl/rsfq_xort_n_cell_if.sv
// rsfq_xort_n_cell_if: signal bundle for the clocked RSFQ XOR cell.
//
// Handshake: there is no valid/ready pair. Every line is toggle-encoded, so a level
// change seen at a posedge of clk is exactly one pulse. The driver (master) may change
// din/trig at any time between edges. The cell (slave) never back-pressures.
// q is toggle-encoded in the same way. pend/viol/viol_cnt are plain levels.
// dbg_st/dbg_vec expose the cell state: in MODE 0 they are the FSM state and a
// one-hot pending index; in MODE 1 they are "any arrival latched" and the arrival vector.
interface rsfq_xort_n_cell_if #(
  parameter int N_IN  = 2,
  parameter int CNT_W = 16
);
  logic [N_IN-1:0]  din;
  logic             trig;
  logic             q;
  logic             pend;
  logic             viol;
  logic [CNT_W-1:0] viol_cnt;
  logic             dbg_st;
  logic [N_IN-1:0]  dbg_vec;

  modport master (
    output din, trig,
    input  q, pend, viol, viol_cnt, dbg_st, dbg_vec
  );

  modport slave (
    input  din, trig,
    output q, pend, viol, viol_cnt, dbg_st, dbg_vec
  );
endinterface

// File: rtl/rsfq_xort_n_cell.sv
// rsfq_xort_n_cell: cycle-based model of a clocked RSFQ XOR cell with N_IN
// toggle-encoded data inputs.
// MODE 0 keeps the 2-input XORT single-pending state machine for any N_IN.
// MODE 1 is odd parity over per-input arrival latches.
// Data pulses load the cell state. A trig pulse evaluates the state and clears it,
// and it may launch a q toggle DELAY_CYC cycles later.
// Optional build macro: XORT_HOLD_CHECK_EN adds hold-time violation flagging
// (viol / viol_cnt). When it is undefined, both outputs are tied to zero.
module rsfq_xort_n_cell #(
  parameter int N_IN      = 2,
  parameter int MODE      = 0,
  parameter int DELAY_CYC = 2,
  parameter int BEGIN_CYC = 8,
  parameter int HOLD_CYC  = 3,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  rsfq_xort_n_cell_if.slave bus
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int SET_W = (BEGIN_CYC > 0) ? $clog2(BEGIN_CYC + 1) : 1;
  localparam logic [SET_W-1:0] SET_INIT = SET_W'(BEGIN_CYC);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_PEND  = 1'b1
  } st_e;

  // Edge-detect history; it is updated every cycle, including during reset.
  logic [N_IN-1:0]      din_prev_q;
  logic                 trig_prev_q;

  // Power-up settle counter.
  logic [SET_W-1:0]     settle_q, settle_d;

  // MODE 0 state: FSM plus pending input index.
  st_e                  st_q, st_d, st_b;
  logic [IDX_W-1:0]     idx_q, idx_d, idx_b;

  // MODE 1 state: arrival latches.
  logic [N_IN-1:0]      arr_q, arr_d, arr_b;

  // Output latency pipe and registered outputs.
  logic [DELAY_CYC-1:0] pipe_q, pipe_d;
  logic                 q_q, q_d;
  logic                 pend_q, pend_d;

  // Per-cycle events after settle gating.
  logic [N_IN-1:0]      p;
  logic                 t;
  logic                 fire_now;
  logic                 chg;

  // Pulse detection; pulses are discarded while the settle counter runs.
  always_comb begin
    p        = bus.din ^ din_prev_q;
    t        = bus.trig ^ trig_prev_q;
    settle_d = settle_q;
    if (settle_q != '0) begin
      p        = '0;
      t        = 1'b0;
      settle_d = settle_q - SET_W'(1);
    end
  end

  // Next-state logic. A trig evaluates the state as it was before this cycle's data
  // pulses. Same-cycle data then lands on the freshly cleared state.
  always_comb begin
    if (MODE == 0) begin
      fire_now = (st_q == ST_PEND);
    end else begin
      fire_now = ^arr_q;
    end

    st_b  = t ? ST_EMPTY : st_q;
    idx_b = t ? '0 : idx_q;
    arr_b = t ? '0 : arr_q;

    // Ascending index order: a second, different input cancels the pending one.
    st_d  = st_b;
    idx_d = idx_b;
    for (int i = 0; i < N_IN; i++) begin
      if (p[i]) begin
        if (st_d == ST_EMPTY) begin
          st_d  = ST_PEND;
          idx_d = IDX_W'(i);
        end else if (idx_d != IDX_W'(i)) begin
          st_d  = ST_EMPTY;
          idx_d = '0;
        end
      end
    end

    arr_d = arr_b | p;

    if (MODE == 0) begin
      arr_d  = '0;
      chg    = (st_d != st_b) || (idx_d != idx_b);
      pend_d = (st_d == ST_PEND);
    end else begin
      st_d   = ST_EMPTY;
      idx_d  = '0;
      chg    = (arr_d != arr_b);
      pend_d = ^arr_d;
    end

    // A trig that finds nothing to fire still shifts a zero through the pipe.
    pipe_d    = pipe_q << 1;
    pipe_d[0] = t & fire_now;
    q_d       = q_q ^ pipe_q[DELAY_CYC-1];
  end

  // Cell state, pipe and outputs. Reset drops in-flight toggles; history always tracks inputs.
  always_ff @(posedge clk) begin
    din_prev_q  <= bus.din;
    trig_prev_q <= bus.trig;
    if (!rst_n) begin
      settle_q <= SET_INIT;
      st_q     <= ST_EMPTY;
      idx_q    <= '0;
      arr_q    <= '0;
      pipe_q   <= '0;
      q_q      <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      settle_q <= settle_d;
      st_q     <= st_d;
      idx_q    <= idx_d;
      arr_q    <= arr_d;
      pipe_q   <= pipe_d;
      q_q      <= q_d;
      pend_q   <= pend_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.pend    = pend_q;
  assign bus.dbg_st  = (MODE == 0) ? (st_q == ST_PEND) : (|arr_q);
  assign bus.dbg_vec = (MODE == 0) ? ((st_q == ST_PEND) ? (N_IN'(1) << idx_q) : '0) : arr_q;

`ifdef XORT_HOLD_CHECK_EN
  localparam int AGE_W = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(HOLD_CYC);
  localparam logic [AGE_W-1:0] AGE_ONE = (HOLD_CYC > 0) ? AGE_W'(1) : AGE_W'(0);
  localparam bit SAME_CYC_HIT = (HOLD_CYC > 0);

  // An age counter holds the cycle distance to the last event of its kind.
  // It saturates at HOLD_CYC, which means "long enough ago".
  logic [AGE_W-1:0] trig_age_q, trig_age_d;
  logic [AGE_W-1:0] chg_age_q, chg_age_d;
  logic [AGE_W-1:0] data_age_q [N_IN];
  logic [AGE_W-1:0] data_age_d [N_IN];
  logic             hit;
  logic             viol_q;
  logic [CNT_W-1:0] viol_cnt_q;

  function automatic logic [AGE_W-1:0] age_step(input logic ev, input logic [AGE_W-1:0] age);
    if (ev) begin
      return AGE_ONE;
    end
    if (age < AGE_MAX) begin
      return age + AGE_W'(1);
    end
    return age;
  endfunction

  // Hold-window checks. Several hits in one cycle count as one violation.
  always_comb begin
    hit        = 1'b0;
    trig_age_d = age_step(t, trig_age_q);
    chg_age_d  = age_step(chg, chg_age_q);
    // Data pulse too soon after (or together with) trig.
    if ((p != '0) && ((SAME_CYC_HIT && t) || (trig_age_q < AGE_MAX))) begin
      hit = 1'b1;
    end
    // Trig too soon after a data pulse that changed state.
    if (t && (chg_age_q < AGE_MAX)) begin
      hit = 1'b1;
    end
    // Data pulse too close to a pulse on a different input.
    for (int i = 0; i < N_IN; i++) begin
      data_age_d[i] = age_step(p[i], data_age_q[i]);
      for (int j = 0; j < N_IN; j++) begin
        if (p[i] && (j != i) && ((SAME_CYC_HIT && p[j]) || (data_age_q[j] < AGE_MAX))) begin
          hit = 1'b1;
        end
      end
    end
  end

  // Age counters and the saturating violation count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trig_age_q <= AGE_MAX;
      chg_age_q  <= AGE_MAX;
      for (int i = 0; i < N_IN; i++) begin
        data_age_q[i] <= AGE_MAX;
      end
      viol_q     <= 1'b0;
      viol_cnt_q <= '0;
    end else begin
      trig_age_q <= trig_age_d;
      chg_age_q  <= chg_age_d;
      for (int i = 0; i < N_IN; i++) begin
        data_age_q[i] <= data_age_d[i];
      end
      viol_q <= hit;
      if (hit && (viol_cnt_q != '1)) begin
        viol_cnt_q <= viol_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.viol     = viol_q;
  assign bus.viol_cnt = viol_cnt_q;
`else
  assign bus.viol     = 1'b0;
  assign bus.viol_cnt = '0;
`endif

endmodule

// File: tb/tb_rsfq_xort_n_cell.sv
// tb_rsfq_xort_n_cell: directed bench for rsfq_xort_n_cell.
// dut0 is N_IN=2, MODE 0, DELAY 2. dut1 is N_IN=4, MODE 1, DELAY 3.
// Inputs change on negedge; outputs are sampled on negedge.
`timescale 1ns/1ps
module tb_rsfq_xort_n_cell;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rsfq_xort_n_cell_if #(.N_IN(2), .CNT_W(16)) if0 ();
  rsfq_xort_n_cell_if #(.N_IN(4), .CNT_W(16)) if1 ();

  rsfq_xort_n_cell #(
    .N_IN(2), .MODE(0), .DELAY_CYC(2), .BEGIN_CYC(8), .HOLD_CYC(3), .CNT_W(16)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );

  rsfq_xort_n_cell #(
    .N_IN(4), .MODE(1), .DELAY_CYC(3), .BEGIN_CYC(8), .HOLD_CYC(3), .CNT_W(16)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic exp_q0 = 1'b0;
  logic exp_q1 = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks (call on a negedge) ----------------
  task automatic drv0(input logic [1:0] dm, input logic tg);
    if0.din  = if0.din ^ dm;
    if0.trig = if0.trig ^ tg;
    @(negedge clk);
  endtask

  task automatic drv1(input logic [3:0] dm, input logic tg);
    if1.din  = if1.din ^ dm;
    if1.trig = if1.trig ^ tg;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    if0.din = '0; if0.trig = 1'b0;
    if1.din = '0; if1.trig = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_q0", {31'd0, if0.q}, 0);
    check("rst_pend0", {31'd0, if0.pend}, 0);
    check("rst_viol_cnt0", {16'd0, if0.viol_cnt}, 0);
    check("rst_q1", {31'd0, if1.q}, 0);

    // Settle: a pulse detected on the 8th post-release edge is ignored; the 9th counts.
    rst_n = 1'b1;
    repeat (7) @(negedge clk);
    drv0(2'b01, 1'b0);
    check("settle_ignore", {31'd0, if0.pend}, 0);
    drv0(2'b01, 1'b0);
    check("t1_pend_set", {31'd0, if0.pend}, 1);
    check("t1_dbg_vec", {30'd0, if0.dbg_vec}, 32'h1);
    repeat (4) @(negedge clk);
    check("t1_pend_hold", {31'd0, if0.pend}, 1);
    drv0(2'b00, 1'b1);
    check("t1_pend_clr", {31'd0, if0.pend}, 0);
    check("t1_q_lat0", {31'd0, if0.q}, 0);
    @(negedge clk);
    check("t1_q_lat1", {31'd0, if0.q}, 0);
    @(negedge clk);
    exp_q0 = ~exp_q0;
    check("t1_q_toggle", {31'd0, if0.q}, {31'd0, exp_q0});

    // Cancel: din[0] then din[1] empties the cell; trig emits nothing.
    drv0(2'b01, 1'b0);
    drv0(2'b10, 1'b0);
    check("t2_cancel_pend", {31'd0, if0.pend}, 0);
    check("t2_cancel_st", {31'd0, if0.dbg_st}, 0);
    drv0(2'b00, 1'b1);
    repeat (2) @(negedge clk);
    check("t2_cancel_q", {31'd0, if0.q}, {31'd0, exp_q0});

    // Repeat on the same input is ignored; trig fires once.
    drv0(2'b01, 1'b0);
    drv0(2'b01, 1'b0);
    check("t2_repeat_pend", {31'd0, if0.pend}, 1);
    check("t2_repeat_vec", {30'd0, if0.dbg_vec}, 32'h1);
    drv0(2'b00, 1'b1);
    repeat (2) @(negedge clk);
    exp_q0 = ~exp_q0;
    check("t2_repeat_q", {31'd0, if0.q}, {31'd0, exp_q0});

    // Same-cycle din[1] and trig with din[0] pending.
    drv0(2'b01, 1'b0);
    drv0(2'b10, 1'b1);
    check("t4_next_pend", {31'd0, if0.pend}, 1);
    check("t4_next_vec", {30'd0, if0.dbg_vec}, 32'h2);
    repeat (2) @(negedge clk);
    exp_q0 = ~exp_q0;
    check("t4_q_first", {31'd0, if0.q}, {31'd0, exp_q0});
    drv0(2'b00, 1'b1);
    check("t4_pend_clr", {31'd0, if0.pend}, 0);
    repeat (2) @(negedge clk);
    exp_q0 = ~exp_q0;
    check("t4_q_second", {31'd0, if0.q}, {31'd0, exp_q0});

    // Both inputs in one cycle: PEND(0), then cancelled by input 1.
    drv0(2'b11, 1'b0);
    check("same_cyc_cancel", {31'd0, if0.pend}, 0);

    // Back-to-back trigs give two independent toggles on consecutive cycles.
    drv0(2'b01, 1'b0);
    drv0(2'b10, 1'b1);
    drv0(2'b00, 1'b1);
    check("b2b_pre", {31'd0, if0.q}, {31'd0, exp_q0});
    @(negedge clk);
    exp_q0 = ~exp_q0;
    check("b2b_first", {31'd0, if0.q}, {31'd0, exp_q0});
    @(negedge clk);
    exp_q0 = ~exp_q0;
    check("b2b_second", {31'd0, if0.q}, {31'd0, exp_q0});

    // Get q to 1, launch another toggle, then reset while it is in flight.
    drv0(2'b01, 1'b0);
    drv0(2'b00, 1'b1);
    repeat (2) @(negedge clk);
    exp_q0 = ~exp_q0;
    check("pre_rst_q", {31'd0, if0.q}, {31'd0, exp_q0});
    drv0(2'b01, 1'b0);
    drv0(2'b00, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_q", {31'd0, if0.q}, 0);
    check("rst_mid_pend", {31'd0, if0.pend}, 0);
    if0.din = if0.din ^ 2'b10;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q0 = 1'b0;
    exp_q1 = 1'b0;
    repeat (14) @(negedge clk);
    check("rst_no_stale_q", {31'd0, if0.q}, 0);
    check("rst_no_pend", {31'd0, if0.pend}, 0);
    check("rst_q1", {31'd0, if1.q}, 0);

    // MODE 1 parity: three arrivals -> odd -> toggle after 3 cycles.
    drv1(4'b0001, 1'b0);
    check("t3_par1", {31'd0, if1.pend}, 1);
    drv1(4'b0010, 1'b0);
    check("t3_par2", {31'd0, if1.pend}, 0);
    drv1(4'b0100, 1'b0);
    check("t3_par3", {31'd0, if1.pend}, 1);
    drv1(4'b0000, 1'b1);
    check("t3_pend_clr", {31'd0, if1.pend}, 0);
    repeat (2) @(negedge clk);
    check("t3_q_early", {31'd0, if1.q}, {31'd0, exp_q1});
    @(negedge clk);
    exp_q1 = ~exp_q1;
    check("t3_q_toggle", {31'd0, if1.q}, {31'd0, exp_q1});

    // All four arrivals -> even -> no toggle.
    drv1(4'b1111, 1'b0);
    check("t3_even_pend", {31'd0, if1.pend}, 0);
    check("t3_even_vec", {28'd0, if1.dbg_vec}, 32'hF);
    drv1(4'b0000, 1'b1);
    repeat (3) @(negedge clk);
    check("t3_even_q", {31'd0, if1.q}, {31'd0, exp_q1});

    // Repeat arrival on one input is latched once.
    drv1(4'b0001, 1'b0);
    drv1(4'b0001, 1'b0);
    check("m1_repeat_pend", {31'd0, if1.pend}, 1);
    check("m1_repeat_vec", {28'd0, if1.dbg_vec}, 32'h1);
    drv1(4'b0000, 1'b1);
    repeat (3) @(negedge clk);
    exp_q1 = ~exp_q1;
    check("m1_repeat_q", {31'd0, if1.q}, {31'd0, exp_q1});

    // Same-cycle data and trig in MODE 1.
    drv1(4'b1000, 1'b0);
    drv1(4'b0010, 1'b1);
    check("m1_next_vec", {28'd0, if1.dbg_vec}, 32'h2);
    repeat (3) @(negedge clk);
    exp_q1 = ~exp_q1;
    check("m1_next_q1", {31'd0, if1.q}, {31'd0, exp_q1});
    drv1(4'b0000, 1'b1);
    repeat (3) @(negedge clk);
    exp_q1 = ~exp_q1;
    check("m1_next_q2", {31'd0, if1.q}, {31'd0, exp_q1});

`ifdef XORT_HOLD_CHECK_EN
    // Hold checks on dut0 with HOLD_CYC=3, starting from a clean reset.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("hold_cnt0", {16'd0, if0.viol_cnt}, 0);
    drv0(2'b00, 1'b1);
    drv0(2'b01, 1'b0);
    check("hold_viol_d1", {31'd0, if0.viol}, 1);
    check("hold_cnt1", {16'd0, if0.viol_cnt}, 1);
    @(negedge clk);
    check("hold_viol_pulse", {31'd0, if0.viol}, 0);
    repeat (2) @(negedge clk);
    drv0(2'b00, 1'b1);
    check("hold_trig_d4", {31'd0, if0.viol}, 0);
    repeat (3) @(negedge clk);
    drv0(2'b10, 1'b0);
    check("hold_data_d4", {31'd0, if0.viol}, 0);
    repeat (2) @(negedge clk);
    drv0(2'b01, 1'b0);
    check("hold_cross_d3", {31'd0, if0.viol}, 0);
    drv0(2'b10, 1'b0);
    check("hold_cross_d1", {31'd0, if0.viol}, 1);
    check("hold_cnt2", {16'd0, if0.viol_cnt}, 2);
`else
    check("no_check_viol0", {31'd0, if0.viol}, 0);
    check("no_check_cnt0", {16'd0, if0.viol_cnt}, 0);
    check("no_check_cnt1", {16'd0, if1.viol_cnt}, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
